mmm_serial_core: RTL and testbench
==================================

# mmm_serial_core

- Bit-serial radix-2 Montgomery modular multiplier: computes `result = a·b·2^(-WIDTH) mod n` in WIDTH+1 enabled cycles.
- It is the responder to the exponentiation control unit: that unit issues `start`, holds operands, and waits for `done` instead of counting fixed cycle budgets.
- It sits in the RSA datapath between the operand/result registers and the exponent-scanning controller.

## Interface
Parameters:
- `WIDTH`, 8: operand, modulus and result width in bits; ≥ 4.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rstb`  in  1  reset; asynchronous, active-low.
- `en`  in  1  clock enable; when low, all state (including `done`) holds.
- `start`  in  1  request; sampled only in IDLE with `en`=1.
- `a`  in  WIDTH  multiplier operand, captured on accepted `start`.
- `b`  in  WIDTH  multiplicand operand, captured on accepted `start`.
- `n`  in  WIDTH  modulus, captured on accepted `start`; must be odd, with a, b < n.
- `result`  out  WIDTH  product; valid from `done` until the next accepted `start`.
- `busy`  out  1  high in CALC and CORR.
- `done`  out  1  one enabled-cycle pulse on completion.

## Operation
- Reset values: state=IDLE, `result`=0, `busy`=0, `done`=0, accumulator=0, bit counter=0.
- States: IDLE → CALC → CORR → IDLE.
- IDLE:
  - `start`=1 loads a, b, n into local registers, clears accumulator R (WIDTH+2 bits) and counter, and moves to CALC.
  - `done` clears on the next enabled edge unless a new `start` is accepted on that edge; `done` clears in that case too.
- CALC, iteration i from 0 to WIDTH-1:
  - t = R + a[i]·b; q = t[0]; R ← (t + q·n) >> 1.
  - After i = WIDTH-1, go to CORR.
- CORR:
  - `result` ← (R ≥ n) ? R − n : R, truncated to WIDTH.
  - `done` ← 1, `busy` ← 0, go to IDLE.
- Width rules:
  - R < 2n holds throughout, so WIDTH+2 bits never overflow.
  - The subtraction is done at WIDTH+2 bits.
- `start` while busy is ignored; no queuing.
- Even n or a, b ≥ n: the result is unspecified, but latency is identical and the FSM returns to IDLE (no hang).
- Operand inputs may change freely after the accepted `start`.
- `rstb` low mid-operation: immediate return to reset values; the partial result is discarded and no `done` pulse occurs.

## Timing
- Accepted `start` at edge T0. CALC occupies edges T1…TWIDTH. CORR writes `result` and `done` at edge TWIDTH+1.
- Latency: WIDTH+1 enabled cycles from start edge to `done` high.
- `busy` is high from just after T0 until just after TWIDTH+1; `busy` and `done` are never high together.
- Back-to-back: `start` held high while `done`=1 is accepted at edge TWIDTH+2. Throughput is one product per WIDTH+2 enabled cycles.
- `en`=0 cycles stretch every interval above cycle-for-cycle; no edge is lost or doubled.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `rsa_pkg`:
  - default `WIDTH` constant;
  - state enum (IDLE, CALC, CORR);
  - counter width `$clog2(WIDTH)`.
- Sub-module `mmm_iter_step`: combinational single iteration. Inputs: R, a_bit, b, n. Output: next R. It is reusable by a future radix-4 core.
- Top contains the FSM, the counter, the operand registers, and the CORR subtract.

## Test plan
- WIDTH=8, n=239, a=17, b=17, start → `done` exactly 9 cycles after start edge, `result`=17.
- n=239, a=1, b=1 → `result`=225; a=238, b=238 → `result`=225; a=0, b=200 → `result`=0.
- Start pulse every cycle during an operation (a=1, b=1) → only the first accepted; single `done`; `result`=225; `busy` high for exactly 9 cycles.
- `en` toggled 0/1 every other cycle during a=17, b=17 → `done` after 9 enabled cycles, `result`=17; `done` held while `en`=0.
- `rstb` asserted at CALC cycle 4, then released → all outputs 0, no `done`; a fresh start completes normally.
- Random a, b < n, odd n, 1000 runs → `result` matches reference model a·b·256⁻¹ mod n; `busy` and `done` never both high.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants, FSM state type and sizing helper for the Montgomery datapath.
package rsa_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, CORR} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/mmm_iter_step.sv
// mmm_iter_step: one combinational radix-2 Montgomery iteration, R' = (R + a_bit*b + q*n) >> 1.
module mmm_iter_step import rsa_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] i_r,
    input  logic             i_a_bit,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH+1:0] o_r
);
    logic [WIDTH+1:0] w_t;
    logic [WIDTH+1:0] w_u;
    assign w_t = i_r + (i_a_bit ? {2'b00, i_b} : '0);
    // Adding n when t is odd makes the sum even, so the shift is an exact divide by two.
    assign w_u = w_t + (w_t[0] ? {2'b00, i_n} : '0);
    assign o_r = w_u >> 1;
endmodule

// File: rtl/mmm_serial_core.sv
// mmm_serial_core: bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod n in WIDTH+1 enabled cycles.
module mmm_serial_core import rsa_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);
    localparam int CW = cnt_width(WIDTH);
    localparam int RW = WIDTH + 2;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_n, r_result;
    logic [RW-1:0]    r_r, w_r_nxt, w_n_ext;
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done, w_last;
    assign w_n_ext = {2'b00, r_n};
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    assign result  = r_result;
    assign busy    = r_busy;
    assign done    = r_done;
    mmm_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_r    (r_r),
        .i_a_bit(r_a[0]),
        .i_b    (r_b),
        .i_n    (r_n),
        .o_r    (w_r_nxt)
    );
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? CALC : IDLE;
            CALC:    w_state_nxt = w_last ? CORR : CALC;
            CORR:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_r      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_busy  <= w_state_nxt != IDLE;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_n   <= n;
                        r_r   <= '0;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    // a is consumed LSB first by shifting, so the step always sees bit 0.
                    r_r   <= w_r_nxt;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                CORR: begin
                    r_result <= WIDTH'((r_r >= w_n_ext) ? r_r - w_n_ext : r_r);
                    r_done   <= 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmm_serial_core.sv
// tb_mmm_serial_core: directed and randomized checks of the serial Montgomery multiplier at WIDTH=8.
module tb_mmm_serial_core;
    localparam int W = 8;
    logic         clk, rstb, en, start;
    logic [W-1:0] a, b, n, result;
    logic         busy, done;
    int           n_chk = 0;
    int           n_fail = 0;
    int           ovl = 0;
    mmm_serial_core #(.WIDTH(W)) dut (
        .clk(clk), .rstb(rstb), .en(en), .start(start),
        .a(a), .b(b), .n(n),
        .result(result), .busy(busy), .done(done)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && done) ovl++;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic logic [W-1:0] ref_mmm(input int ia, input int ib, input int in_);
        int x;
        x = (ia * ib) % in_;
        repeat (W) x = (x % 2 != 0) ? (x + in_) / 2 : x / 2;
        return W'(x);
    endfunction
    task automatic run_op(input int ia, input int ib, input int in_, input int exp,
                          input string tag, input bit chk_lat);
        int cyc;
        a = W'(ia); b = W'(ib); n = W'(in_); start = 1'b1;
        tick();
        start = 1'b0;
        a = '0; b = '0; n = '0;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_done"}, 32'(done), 1);
        if (chk_lat) check({tag, "_latency"}, cyc, W + 1);
        check({tag, "_result"}, 32'(result), exp);
        tick();
    endtask
    initial begin
        int bc, dc, ec;
        rstb = 1'b0; en = 1'b1; start = 1'b0; a = '0; b = '0; n = '0;
        tick(); tick();
        check("rst_result", 32'(result), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rstb = 1'b1;
        tick();
        run_op(17, 17, 239, 17, "mul17", 1'b1);
        check("done_clears", 32'(done), 0);
        run_op(1, 1, 239, 225, "mul1", 1'b1);
        run_op(238, 238, 239, 225, "mul238", 1'b1);
        run_op(0, 200, 239, 0, "mul0", 1'b1);
        // start held every cycle; operands scrambled after acceptance
        a = 8'd1; b = 8'd1; n = 8'd239; start = 1'b1;
        tick();
        a = 8'd3; b = 8'd5; n = 8'd11;
        bc = busy ? 1 : 0;
        dc = 0;
        for (int i = 1; i <= W + 1; i++) begin
            tick();
            if (busy) bc++;
            if (done) dc++;
        end
        start = 1'b0;
        check("hold_busy_cycles", bc, W + 1);
        check("hold_done_count", dc, 1);
        check("hold_result", 32'(result), 225);
        tick();
        check("hold_no_restart", 32'(busy), 0);
        check("hold_done_clear", 32'(done), 0);
        // clock enable toggling
        a = 8'd17; b = 8'd17; n = 8'd239; start = 1'b1;
        tick();
        start = 1'b0;
        ec = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            en = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (en) ec++;
        end
        check("en_done", 32'(done), 1);
        check("en_enabled_cycles", ec, W + 1);
        check("en_result", 32'(result), 17);
        en = 1'b0;
        tick(); tick();
        check("en_done_held", 32'(done), 1);
        en = 1'b1;
        tick();
        check("en_done_drop", 32'(done), 0);
        // reset in the middle of CALC
        a = 8'd17; b = 8'd17; n = 8'd239; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy_before", 32'(busy), 1);
        rstb = 1'b0;
        #1;
        check("mid_rst_result", 32'(result), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        tick();
        rstb = 1'b1;
        dc = 0;
        repeat (12) begin
            tick();
            if (done || busy) dc++;
        end
        check("mid_rst_quiet", dc, 0);
        run_op(17, 17, 239, 17, "after_rst", 1'b1);
        run_op(100, 50, 101, ref_mmm(100, 50, 101), "m101", 1'b1);
        for (int r = 0; r < 1000; r++) begin
            int rn, ra, rb;
            rn = 2 * $urandom_range(1, 127) + 1;
            ra = $urandom_range(0, rn - 1);
            rb = $urandom_range(0, rn - 1);
            run_op(ra, rb, rn, ref_mmm(ra, rb, rn), "rand", 1'b0);
        end
        check("busy_done_exclusive", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
